// File: rtl/mem_bist_chk_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_bist_chk_if
// Description : Write/read handshake bundle between the memory self-test
//               engine and one memory port. It uses the same
//               rdy/en/data_valid protocol that the frame buffer uses toward
//               ram_int_4p.
//
//   Signals
//     wr_rdy        : memory accepts a write this cycle
//     wr_en         : write strobe (only ever high together with wr_rdy)
//     wr_addr       : write address
//     wr_data       : write data
//     rd_rdy        : memory accepts a read request this cycle
//     rd_en         : read request strobe (only ever high with rd_rdy)
//     rd_addr       : read address
//     rd_data       : returned read data
//     rd_data_valid : rd_data valid; data returns in request order
//
//   Modports
//     master : the test engine (drives strobes, addresses, write data)
//     slave  : the memory (drives ready flags and read data)
//
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_bist_chk_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 24
);
   logic              wr_rdy;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              rd_rdy;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              rd_data_valid;

   modport master (
      input  wr_rdy,
      output wr_en,
      output wr_addr,
      output wr_data,
      input  rd_rdy,
      output rd_en,
      output rd_addr,
      input  rd_data,
      input  rd_data_valid
   );

   modport slave (
      output wr_rdy,
      input  wr_en,
      input  wr_addr,
      input  wr_data,
      output rd_rdy,
      input  rd_en,
      input  rd_addr,
      output rd_data,
      output rd_data_valid
   );
endinterface
`default_nettype wire

// File: rtl/mem_bist_chk.sv
`default_nettype none
// ============================================================================
// Module      : mem_bist_chk
// Description : Memory self-test engine for the image-capture frame store.
//               It writes a selectable pattern to NUM_WORDS consecutive
//               addresses starting at 0, reads every word back and compares
//               it against an independently regenerated pattern. The engine
//               reports pass/fail, a saturating error count and the address
//               of the first failing word.
//
//   Parameters
//     DATA_W    : data word width (8..64)
//     ADDR_W    : address width
//     NUM_WORDS : number of words tested (1..2^ADDR_W)
//     ERR_W     : error counter width
//
//   Ports
//     clk            : single clock, rising edge
//     reset          : asynchronous reset, active low
//     start          : begins a run when high in IDLE or DONE
//     mode           : pattern select, sampled at start
//                        0 fixed_patt, 1 address, 2 walking one,
//                        3 checkerboard
//     fixed_patt     : pattern for mode 0, sampled at start
//     mem            : memory handshake bundle (master side)
//     busy           : a run is in progress
//     done           : the run has finished
//     pass           : done and no mismatches
//     fail           : sticky mismatch flag, cleared by start or reset
//     err_cnt        : mismatch count, saturates at all-ones
//     first_err_addr : address of the first mismatch
//
//   Build option
//     MEM_BIST_ERR_LOG_EN : when defined, first_err_addr is captured.
//                           When undefined, the capture register is not
//                           built and first_err_addr is tied to 0.
//
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bist_chk #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 24,
   parameter int NUM_WORDS = 503,
   parameter int ERR_W     = 16
) (
   input  wire                 clk,
   input  wire                 reset,
   input  wire                 start,
   input  wire  [1:0]          mode,
   input  wire  [DATA_W-1:0]   fixed_patt,
   mem_bist_chk_if.master      mem,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic                fail,
   output logic [ERR_W-1:0]    err_cnt,
   output logic [ADDR_W-1:0]   first_err_addr
);

   // -------------------------------------------------------------------------
   // Constants
   // -------------------------------------------------------------------------
   // The check counter must be able to hold NUM_WORDS itself, which can be
   // 2^ADDR_W, so it carries one bit more than an address.
   localparam int                c_cnt_w     = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(NUM_WORDS - 1);
   localparam logic [ADDR_W-1:0] c_addr_one  = ADDR_W'(1);
   localparam logic [c_cnt_w-1:0] c_num_cnt  = c_cnt_w'(NUM_WORDS);
   localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
   localparam logic [ERR_W-1:0]  c_err_one   = ERR_W'(1);
   localparam logic [DATA_W-1:0] c_data_one  = DATA_W'(1);
   localparam logic [DATA_W-1:0] c_checker   = {(DATA_W/2){2'b10}};
   // The modulo for the walking-one bit position is evaluated at a width that
   // holds both the address and DATA_W (DATA_W <= 64 needs 7 bits).
   localparam int                c_mod_w     = (ADDR_W > 7) ? ADDR_W : 7;

   // -------------------------------------------------------------------------
   // State machine encoding
   // -------------------------------------------------------------------------
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WRITE = 3'd1,
      S_READ  = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   // -------------------------------------------------------------------------
   // Registers and wires
   // -------------------------------------------------------------------------
   logic [1:0]         r_mode;
   logic [DATA_W-1:0]  r_patt;
   logic [ADDR_W-1:0]  r_wr_addr;
   logic [DATA_W-1:0]  r_wr_data;
   logic [ADDR_W-1:0]  r_rd_addr;
   logic [c_cnt_w-1:0] r_chk_cnt;
   logic               r_fail;
   logic [ERR_W-1:0]   r_err_cnt;

   logic               w_start_run;
   logic               w_wr_en;
   logic               w_rd_en;
   logic [ADDR_W-1:0]  w_wr_addr_inc;
   logic [ADDR_W-1:0]  w_chk_addr;
   logic [DATA_W-1:0]  w_chk_patt;
   logic               w_chk_hit;
   logic               w_mismatch;

   // -------------------------------------------------------------------------
   // Pattern generator. The write side and the check side each call it with
   // their own address, so the checker never depends on what was written.
   // -------------------------------------------------------------------------
   function automatic logic [DATA_W-1:0] f_patt(
      input logic [1:0]        m,
      input logic [DATA_W-1:0] fp,
      input logic [ADDR_W-1:0] a
   );
      logic [DATA_W-1:0] p;
      case (m)
         2'd0:    p = fp;
         // Size cast zero-extends or truncates as the widths require.
         2'd1:    p = DATA_W'(a);
         2'd2:    p = c_data_one << (c_mod_w'(a) % c_mod_w'(DATA_W));
         default: p = a[0] ? ~c_checker : c_checker;
      endcase
      return p;
   endfunction

   // A run may only be launched from a resting state. A start seen while
   // busy is ignored.
   assign w_start_run   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_wr_addr_inc = r_wr_addr + c_addr_one;

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next state and strobes. The strobes follow the ready flags
   // combinationally, which gives one transfer per cycle while ready stays
   // high and never strobes without ready.
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_wr_en     = 1'b0;
      w_rd_en     = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_state_nxt = S_WRITE;
            end
         end
         S_WRITE: begin
            w_wr_en = mem.wr_rdy;
            if (mem.wr_rdy && (r_wr_addr == c_last_addr)) begin
               w_state_nxt = S_READ;
            end
         end
         S_READ: begin
            w_rd_en = mem.rd_rdy;
            if (mem.rd_rdy && (r_rd_addr == c_last_addr)) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (r_chk_cnt == c_num_cnt) begin
               w_state_nxt = S_DONE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Checker. Returned data is accepted only while reads can be outstanding
   // (READ/DRAIN) and only until NUM_WORDS words have been checked. This
   // drops stale beats that arrive after a reset or alongside a restart.
   // -------------------------------------------------------------------------
   assign w_chk_addr = r_chk_cnt[ADDR_W-1:0];
   assign w_chk_patt = f_patt(r_mode, r_patt, w_chk_addr);
   assign w_chk_hit  = ((r_state == S_READ) || (r_state == S_DRAIN)) &&
                       mem.rd_data_valid && (r_chk_cnt != c_num_cnt);
   assign w_mismatch = (mem.rd_data != w_chk_patt);

   // -------------------------------------------------------------------------
   // Datapath: addresses, write data, check counter and result registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mode    <= 2'd0;
         r_patt    <= '0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_rd_addr <= '0;
         r_chk_cnt <= '0;
         r_fail    <= 1'b0;
         r_err_cnt <= '0;
      end else if (w_start_run) begin
         // Latch the run configuration and preload the first write beat so
         // that wr_data is already valid in the first WRITE cycle.
         r_mode    <= mode;
         r_patt    <= fixed_patt;
         r_wr_addr <= '0;
         r_wr_data <= f_patt(mode, fixed_patt, '0);
         r_rd_addr <= '0;
         r_chk_cnt <= '0;
         r_fail    <= 1'b0;
         r_err_cnt <= '0;
      end else begin
         // Write side: advance only on an accepted beat. The address and data
         // are otherwise held. They return to 0 after the last beat.
         if (w_wr_en) begin
            if (r_wr_addr == c_last_addr) begin
               r_wr_addr <= '0;
               r_wr_data <= '0;
            end else begin
               r_wr_addr <= w_wr_addr_inc;
               r_wr_data <= f_patt(r_mode, r_patt, w_wr_addr_inc);
            end
         end

         // Read side: same hold-while-not-ready behaviour.
         if (w_rd_en) begin
            if (r_rd_addr == c_last_addr) begin
               r_rd_addr <= '0;
            end else begin
               r_rd_addr <= r_rd_addr + c_addr_one;
            end
         end

         if (w_chk_hit) begin
            r_chk_cnt <= r_chk_cnt + c_cnt_one;
            if (w_mismatch) begin
               r_fail <= 1'b1;
               if (r_err_cnt != {ERR_W{1'b1}}) begin
                  r_err_cnt <= r_err_cnt + c_err_one;
               end
            end
         end
      end
   end

   // -------------------------------------------------------------------------
   // First failing address. It is captured while fail is still clear, which
   // makes the mismatch the first one of the run.
   // -------------------------------------------------------------------------
`ifdef MEM_BIST_ERR_LOG_EN
   logic [ADDR_W-1:0] r_first_err_addr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_first_err_addr <= '0;
      end else if (w_start_run) begin
         r_first_err_addr <= '0;
      end else if (w_chk_hit && w_mismatch && !r_fail) begin
         r_first_err_addr <= w_chk_addr;
      end
   end

   assign first_err_addr = r_first_err_addr;
`else
   assign first_err_addr = '0;
`endif

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign mem.wr_en   = w_wr_en;
   assign mem.wr_addr = r_wr_addr;
   assign mem.wr_data = r_wr_data;
   assign mem.rd_en   = w_rd_en;
   assign mem.rd_addr = r_rd_addr;

   // busy and done both decode the state register. busy therefore rises the
   // cycle after start and falls in the same cycle that done rises.
   assign busy    = (r_state == S_WRITE) || (r_state == S_READ) || (r_state == S_DRAIN);
   assign done    = (r_state == S_DONE);
   assign pass    = done && (r_err_cnt == '0);
   assign fail    = r_fail;
   assign err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_bist_chk.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bist_chk
// Description : Self-checking bench for mem_bist_chk. A behavioural memory
//               with a 3-cycle read latency and selectable corruption
//               (none / bit-0 flip at 0x10 and 0x20 / stuck-at-0) sits on
//               the interface. For every run the expected write beats and
//               read addresses are queued up front and popped as the DUT
//               strobes them. The final status is compared against values
//               derived by the bench. MEM_BIST_ERR_LOG_EN selects the
//               expected first_err_addr.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bist_chk;
   localparam int DATA_W    = 32;
   localparam int ADDR_W    = 24;
   localparam int NUM_WORDS = 503;
   localparam int ERR_W     = 4;

`ifdef MEM_BIST_ERR_LOG_EN
   localparam logic [23:0] EXP_FEA_T2 = 24'h10;
`else
   localparam logic [23:0] EXP_FEA_T2 = 24'h0;
`endif

   logic              clk        = 1'b0;
   logic              reset      = 1'b0;
   logic              start      = 1'b0;
   logic [1:0]        mode       = 2'd0;
   logic [31:0]       fixed_patt = 32'h0;
   logic              busy;
   logic              done;
   logic              pass;
   logic              fail;
   logic [ERR_W-1:0]  err_cnt;
   logic [23:0]       first_err_addr;

   mem_bist_chk_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mem_if ();

   mem_bist_chk #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .NUM_WORDS (NUM_WORDS),
      .ERR_W     (ERR_W)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .mode           (mode),
      .fixed_patt     (fixed_patt),
      .mem            (mem_if),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .fail           (fail),
      .err_cnt        (err_cnt),
      .first_err_addr (first_err_addr)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------- checking
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Reference pattern, written directly from the pattern definitions.
   function automatic logic [31:0] ref_patt(input logic [1:0] m, input logic [31:0] fp,
                                            input logic [23:0] a);
      case (m)
         2'd0:    return fp;
         2'd1:    return {8'h00, a};
         2'd2:    return 32'h1 << a[4:0];
         default: return a[0] ? 32'h5555_5555 : 32'hAAAA_AAAA;
      endcase
   endfunction

   // ------------------------------------------------------------ memory model
   int          corrupt   = 0;     // 0 none, 1 flip bit 0 at 0x10/0x20, 2 stuck-at-0
   logic        inj_valid = 1'b0;  // extra rd_data_valid pulses from the bench
   bit          rand_rdy  = 1'b0;
   logic [31:0] mem_arr [0:511];
   logic [2:0]  pipe_v = 3'b000;
   logic [31:0] pipe_d [0:2];

   function automatic logic [31:0] mem_read(input logic [31:0] d, input logic [23:0] a);
      case (corrupt)
         1:       return ((a == 24'h10) || (a == 24'h20)) ? (d ^ 32'h1) : d;
         2:       return 32'h0;
         default: return d;
      endcase
   endfunction

   always @(posedge clk) begin
      if (mem_if.wr_en && mem_if.wr_rdy)
         mem_arr[mem_if.wr_addr[8:0]] <= mem_if.wr_data;
      pipe_v    <= {pipe_v[1:0], mem_if.rd_en && mem_if.rd_rdy};
      pipe_d[0] <= mem_read(mem_arr[mem_if.rd_addr[8:0]], mem_if.rd_addr);
      pipe_d[1] <= pipe_d[0];
      pipe_d[2] <= pipe_d[1];
   end

   assign mem_if.rd_data_valid = pipe_v[2] | inj_valid;
   assign mem_if.rd_data       = pipe_d[2];

   initial begin
      mem_if.wr_rdy = 1'b1;
      mem_if.rd_rdy = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (rand_rdy) begin
            mem_if.wr_rdy = 1'($urandom_range(0, 1));
            mem_if.rd_rdy = 1'($urandom_range(0, 1));
         end else begin
            mem_if.wr_rdy = 1'b1;
            mem_if.rd_rdy = 1'b1;
         end
      end
   end

   // -------------------------------------------------------------- scoreboard
   typedef struct packed {
      logic [23:0] a;
      logic [31:0] d;
   } wr_beat_t;

   wr_beat_t    exp_wr[$];
   logic [23:0] exp_rd[$];
   wr_beat_t    mon_wr;
   logic [23:0] mon_rd;

   task automatic push_expect(input logic [1:0] m, input logic [31:0] fp);
      for (int a = 0; a < NUM_WORDS; a++) begin
         wr_beat_t b;
         b.a = 24'(a);
         b.d = ref_patt(m, fp, 24'(a));
         exp_wr.push_back(b);
         exp_rd.push_back(24'(a));
      end
   endtask

   // Strobes are sampled mid-cycle. A strobe seen here is accepted at the
   // next rising edge.
   always @(negedge clk) begin
      if (mem_if.wr_en) begin
         check("wr_en_without_rdy", mem_if.wr_rdy, 1);
         check("wr_beat_expected", exp_wr.size() != 0, 1);
         if (exp_wr.size() != 0) begin
            mon_wr = exp_wr.pop_front();
            check("wr_addr", mem_if.wr_addr, mon_wr.a);
            check("wr_data", mem_if.wr_data, mon_wr.d);
         end
      end
      if (mem_if.rd_en) begin
         check("rd_en_without_rdy", mem_if.rd_rdy, 1);
         check("rd_beat_expected", exp_rd.size() != 0, 1);
         if (exp_rd.size() != 0) begin
            mon_rd = exp_rd.pop_front();
            check("rd_addr", mem_if.rd_addr, mon_rd);
         end
      end
   end

   // ------------------------------------------------------------------ tasks
   // Called #1 after a rising edge.
   task automatic start_run(input logic [1:0] m, input logic [31:0] fp, input logic inj);
      push_expect(m, fp);
      start      = 1'b1;
      mode       = m;
      fixed_patt = fp;
      inj_valid  = inj;
      @(posedge clk);
      #1;
      start     = 1'b0;
      inj_valid = 1'b0;
      check("busy_after_start", busy, 1);
      check("done_after_start", done, 0);
      check("fail_cleared", fail, 0);
      check("err_cleared", err_cnt, 0);
      check("fea_cleared", first_err_addr, 0);
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!done && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("done_within_budget", done, 1);
      check("busy_low_at_done", busy, 0);
      check("wr_queue_drained", exp_wr.size(), 0);
      check("rd_queue_drained", exp_rd.size(), 0);
      check("wr_addr_zero_at_done", mem_if.wr_addr, 0);
      check("wr_data_zero_at_done", mem_if.wr_data, 0);
      check("rd_addr_zero_at_done", mem_if.rd_addr, 0);
   endtask

   task automatic check_results(input string t, input logic e_pass, input logic e_fail,
                                input logic [ERR_W-1:0] e_err, input logic [23:0] e_fea);
      check({t, "_done"}, done, 1);
      check({t, "_pass"}, pass, e_pass);
      check({t, "_fail"}, fail, e_fail);
      check({t, "_err_cnt"}, err_cnt, e_err);
      check({t, "_first_err_addr"}, first_err_addr, e_fea);
   endtask

   task automatic check_idle(input string t);
      check({t, "_busy"}, busy, 0);
      check({t, "_done"}, done, 0);
      check({t, "_pass"}, pass, 0);
      check({t, "_fail"}, fail, 0);
      check({t, "_err_cnt"}, err_cnt, 0);
      check({t, "_first_err_addr"}, first_err_addr, 0);
      check({t, "_wr_en"}, mem_if.wr_en, 0);
      check({t, "_rd_en"}, mem_if.rd_en, 0);
      check({t, "_wr_addr"}, mem_if.wr_addr, 0);
      check({t, "_wr_data"}, mem_if.wr_data, 0);
      check({t, "_rd_addr"}, mem_if.rd_addr, 0);
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      int n;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_idle("in_reset");
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_idle("after_reset");

      // Mode 0, 24'hFFFFFF zero-extended, rdy always high, clean memory.
      corrupt = 0;
      start_run(2'd0, 32'h00FF_FFFF, 1'b0);
      wait_done(10000);
      check_results("t1_fixed", 1'b1, 1'b0, 4'd0, 24'h0);

      // Mode 1, bit 0 corrupted at 0x10 and 0x20.
      corrupt = 1;
      start_run(2'd1, 32'h0, 1'b0);
      wait_done(10000);
      check_results("t2_addr_corrupt", 1'b0, 1'b1, 4'd2, EXP_FEA_T2);

      // Mode 2, random 50% ready on both sides.
      corrupt  = 0;
      rand_rdy = 1'b1;
      start_run(2'd2, 32'h0, 1'b0);
      wait_done(20000);
      rand_rdy = 1'b0;
      check_results("t3_walk_rand", 1'b1, 1'b0, 4'd0, 24'h0);

      // Mode 3 against a stuck-at-0 memory: every word fails. First failure
      // is address 0, so first_err_addr is 0 in either build.
      corrupt = 2;
      start_run(2'd3, 32'h0, 1'b0);
      wait_done(10000);
      check_results("t4_stuck0", 1'b0, 1'b1, 4'hF, 24'h0);

      // Restart from DONE with a stray rd_data_valid in the same cycle.
      corrupt = 0;
      start_run(2'd0, 32'hA5A5_0F0F, 1'b1);
      wait_done(10000);
      check_results("t5_restart", 1'b1, 1'b0, 4'd0, 24'h0);

      // Reset in the middle of READ, then late read data.
      start_run(2'd1, 32'h0, 1'b0);
      n = 0;
      while (mem_if.rd_addr < 24'd8 && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("t6_reached_read", mem_if.rd_addr >= 24'd8, 1);
      reset = 1'b0;
      #2;
      check("t6_async_busy", busy, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      exp_wr.delete();
      exp_rd.delete();
      inj_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      inj_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_idle("t6_after_mid_reset");
      start_run(2'd1, 32'h0, 1'b0);
      wait_done(10000);
      check_results("t6_rerun", 1'b1, 1'b0, 4'd0, 24'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
